// File: rtl/postfix_pkg.sv
// postfix_pkg: opcodes, error codes and FSM states shared by the postfix evaluator.
package postfix_pkg;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_NEG = 4'b1000;
    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_UNDER = 3'd1;
    localparam logic [2:0] ERR_OVER  = 3'd2;
    localparam logic [2:0] ERR_OPC   = 3'd3;
    localparam logic [2:0] ERR_DEPTH = 3'd4;
    typedef enum logic {IDLE, ACCUM} state_t;
endpackage

// File: rtl/postfix_eval_p_if.sv
// postfix_eval_p_if: token stream in, result/status out.
interface postfix_eval_p_if #(parameter int DATA_W = 16, parameter int IN_W = 4);
    logic              IN_VALID;
    logic [IN_W-1:0]   IN;
    logic              OP_MODE;
    logic              OUT_VALID;
    logic [DATA_W-1:0] OUT;
    logic [2:0]        OUT_ERR;
    modport master (output IN_VALID, IN, OP_MODE, input OUT_VALID, OUT, OUT_ERR);
    modport slave  (input IN_VALID, IN, OP_MODE, output OUT_VALID, OUT, OUT_ERR);
endinterface

// File: rtl/postfix_alu.sv
// postfix_alu: combinational wrap-around arithmetic for one postfix operator.
module postfix_alu
    import postfix_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              illegal
);
    always_comb begin
        result  = opcode == OP_ADD ? b + a :
                  opcode == OP_SUB ? b - a :
                  opcode == OP_MUL ? b * a :
                  opcode == OP_NEG ? '0 - a : '0;
        illegal = !(opcode inside {OP_ADD, OP_SUB, OP_MUL, OP_NEG});
    end
endmodule

// File: rtl/postfix_eval_p.sv
// postfix_eval_p: stack-based RPN evaluator with sticky error detection,
// one result/status pulse per IN_VALID run.
module postfix_eval_p
    import postfix_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IN_W   = 4,
    parameter int DEPTH  = 8
) (
    input  logic CLK,
    input  logic RESET,
    postfix_eval_p_if.slave bus
);
    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_stack [DEPTH];
    logic [PW-1:0]     r_sp;
    logic [2:0]        r_err;
    state_t            r_state;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out;
    logic [2:0]        r_out_err;

    state_t            w_state_nxt;
    logic              w_emit, w_do, w_bin, w_illegal;
    logic [3:0]        w_opc;
    logic [2:0]        w_tok_err;
    logic [PW-1:0]     w_sp_nxt, w_wi;
    logic [DATA_W-1:0] w_a, w_b, w_alu, w_wd;

    assign w_opc = 4'(bus.IN);
    assign w_a   = r_stack[AW'(r_sp - PW'(1))];
    assign w_b   = r_stack[AW'(r_sp - PW'(2))];

    postfix_alu #(.DATA_W(DATA_W)) u_alu (
        .a(w_a), .b(w_b), .opcode(w_opc), .result(w_alu), .illegal(w_illegal)
    );

    always_comb begin
        w_state_nxt = bus.IN_VALID ? ACCUM : IDLE;
        w_emit      = (r_state == ACCUM) && !bus.IN_VALID;
        w_bin       = w_opc inside {OP_ADD, OP_SUB, OP_MUL};
        // Non-binary legal opcode is NEG, which only needs one entry.
        w_tok_err   = !bus.OP_MODE ? (r_sp == PW'(DEPTH) ? ERR_OVER : ERR_NONE) :
                      w_illegal ? ERR_OPC :
                      ((w_bin && r_sp < PW'(2)) || (!w_bin && r_sp == '0)) ? ERR_UNDER : ERR_NONE;
        w_do        = bus.IN_VALID && r_err == ERR_NONE && w_tok_err == ERR_NONE;
        w_wi        = !bus.OP_MODE ? r_sp : w_bin ? r_sp - PW'(2) : r_sp - PW'(1);
        w_wd        = !bus.OP_MODE ? DATA_W'(bus.IN) : w_alu;
        w_sp_nxt    = !bus.OP_MODE ? r_sp + PW'(1) : w_bin ? r_sp - PW'(1) : r_sp;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= IDLE;
            r_sp        <= '0;
            r_err       <= ERR_NONE;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_err   <= ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out     <= (r_err == ERR_NONE && r_sp == PW'(1)) ? r_stack[0] : '0;
                r_out_err <= r_err != ERR_NONE ? r_err : r_sp != PW'(1) ? ERR_DEPTH : ERR_NONE;
                r_sp      <= '0;
                r_err     <= ERR_NONE;
            end else if (bus.IN_VALID) begin
                r_err <= r_err != ERR_NONE ? r_err : w_tok_err;
                if (w_do) r_sp <= w_sp_nxt;
            end
        end
    end

    // Stack contents are don't-care after reset, so storage carries no reset.
    always_ff @(posedge CLK) begin
        if (w_do) r_stack[AW'(w_wi)] <= w_wd;
    end

    assign bus.OUT_VALID = r_out_valid;
    assign bus.OUT       = r_out;
    assign bus.OUT_ERR   = r_out_err;
endmodule

// File: tb/tb_postfix_eval_p.sv
// tb_postfix_eval_p: directed vectors for the 16-bit/8-deep and 8-bit/4-deep evaluators.
module tb_postfix_eval_p;
    import postfix_pkg::*;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    postfix_eval_p_if #(.DATA_W(16), .IN_W(4)) b16();
    postfix_eval_p_if #(.DATA_W(8),  .IN_W(4)) b8();

    postfix_eval_p #(.DATA_W(16), .IN_W(4), .DEPTH(8)) dut16 (.CLK(CLK), .RESET(RESET), .bus(b16));
    postfix_eval_p #(.DATA_W(8),  .IN_W(4), .DEPTH(4)) dut8  (.CLK(CLK), .RESET(RESET), .bus(b8));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tok(input bit w, input logic m, input logic [3:0] v);
        @(negedge CLK);
        chk("quiet_valid", w ? b8.OUT_VALID : b16.OUT_VALID, 0);
        if (w) begin b8.IN_VALID = 1'b1; b8.IN = v; b8.OP_MODE = m; end
        else begin b16.IN_VALID = 1'b1; b16.IN = v; b16.OP_MODE = m; end
    endtask

    task automatic psh(input bit w, input logic [3:0] v); tok(w, 1'b0, v); endtask
    task automatic opr(input bit w, input logic [3:0] c); tok(w, 1'b1, c); endtask

    task automatic emit(input string tag, input bit w, input logic [15:0] eo, input logic [2:0] ee);
        @(negedge CLK);
        b16.IN_VALID = 1'b0;
        b8.IN_VALID  = 1'b0;
        @(negedge CLK);
        chk({tag, "_valid"}, w ? b8.OUT_VALID : b16.OUT_VALID, 1);
        chk({tag, "_out"},   w ? 32'(b8.OUT) : 32'(b16.OUT), 32'(eo));
        chk({tag, "_err"},   w ? b8.OUT_ERR : b16.OUT_ERR, 32'(ee));
    endtask

    task automatic ok_sum(input string tag);
        psh(0, 2); psh(0, 3); opr(0, OP_ADD); emit(tag, 0, 16'd5, ERR_NONE);
    endtask

    initial begin
        b16.IN_VALID = 1'b0; b16.IN = '0; b16.OP_MODE = 1'b0;
        b8.IN_VALID  = 1'b0; b8.IN  = '0; b8.OP_MODE  = 1'b0;
        #3 RESET = 1'b0;
        #1;
        chk("rst_valid", b16.OUT_VALID, 0);
        chk("rst_out",   b16.OUT, 0);
        chk("rst_err",   b16.OUT_ERR, 0);
        @(negedge CLK); RESET = 1'b1;

        psh(0, 3); psh(0, 4); opr(0, OP_ADD); psh(0, 2); opr(0, OP_MUL);
        emit("mix14", 0, 16'd14, ERR_NONE);
        psh(0, 3); psh(0, 5); opr(0, OP_SUB);
        emit("sub_wrap", 0, 16'hFFFE, ERR_NONE);
        psh(0, 7); opr(0, OP_NEG);
        emit("neg", 0, 16'hFFF9, ERR_NONE);
        psh(0, 15); psh(0, 15); opr(0, OP_MUL); psh(0, 15); opr(0, OP_MUL);
        psh(0, 15); opr(0, OP_MUL); psh(0, 15); opr(0, OP_MUL);
        emit("mul_wrap", 0, 16'h964F, ERR_NONE);

        psh(0, 3); opr(0, OP_ADD);
        emit("underflow", 0, 16'd0, ERR_UNDER);
        ok_sum("rec_under");
        for (int i = 0; i < 9; i++) psh(0, 4'(i + 1));
        emit("overflow", 0, 16'd0, ERR_OVER);
        ok_sum("rec_over");
        opr(0, 4'b0011);
        emit("bad_opc", 0, 16'd0, ERR_OPC);
        ok_sum("rec_opc");
        psh(0, 1); psh(0, 2);
        emit("depth", 0, 16'd0, ERR_DEPTH);
        ok_sum("rec_depth");
        opr(0, OP_NEG); opr(0, 4'b0011); psh(0, 1);
        emit("first_wins", 0, 16'd0, ERR_UNDER);
        psh(0, 6); opr(0, 4'b1111); psh(0, 2); opr(0, OP_ADD);
        emit("sticky_opc", 0, 16'd0, ERR_OPC);
        ok_sum("rec_sticky");

        psh(0, 6); psh(0, 7);
        @(negedge CLK);
        RESET = 1'b0;
        b16.IN_VALID = 1'b0;
        #1;
        chk("mid_rst_valid", b16.OUT_VALID, 0);
        chk("mid_rst_out",   b16.OUT, 0);
        chk("mid_rst_err",   b16.OUT_ERR, 0);
        @(negedge CLK);
        chk("mid_rst_quiet", b16.OUT_VALID, 0);
        RESET = 1'b1;
        psh(0, 1); psh(0, 1); opr(0, OP_ADD);
        emit("after_rst", 0, 16'd2, ERR_NONE);

        psh(1, 15); psh(1, 15); opr(1, OP_MUL);
        emit("w8_mul", 1, 16'h00E1, ERR_NONE);
        for (int i = 0; i < 5; i++) psh(1, 4'(i));
        emit("w8_over", 1, 16'd0, ERR_OVER);
        psh(1, 2); opr(1, OP_NEG);
        emit("w8_neg", 1, 16'h00FE, ERR_NONE);

        @(negedge CLK);
        chk("end_quiet", b16.OUT_VALID, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/postfix_eval_p.md
Name: postfix_eval_p

Overview:
Parametrised postfix (RPN) expression evaluator, next generation of the team's fixed 16-bit/8-deep postfix unit. It accepts a token stream (operands or operator codes) while IN_VALID is high. It evaluates the stream on an internal stack of configurable width and depth and emits one result per expression. Adds error detection (underflow, overflow, illegal opcode, unbalanced expression), defined wrap arithmetic and clean reset-mid-expression behaviour.

Parameters:
DATA_W, 16, stack entry and result width (bits)
IN_W, 4, token width; operands are zero-extended to DATA_W
DEPTH, 8, stack entries; pointer width clog2(DEPTH+1)

Ports:
CLK  input  1  clock, rising-edge
RESET  input  1  asynchronous, active-low reset
IN_VALID  input  1  high for every token of an expression; the run of high cycles is one expression
IN  input  IN_W  operand value (OP_MODE=0) or opcode (OP_MODE=1)
OP_MODE  input  1  0 = push operand, 1 = operator
OUT_VALID  output  1  one-cycle pulse, result/status valid
OUT  output  DATA_W  result; 0 when OUT_ERR != 0
OUT_ERR  output  3  0 ok, 1 underflow, 2 overflow, 3 illegal opcode, 4 final depth != 1

Behaviour:
- Reset (RESET=0, async): OUT_VALID=0, OUT=0, OUT_ERR=0, stack pointer=0, sticky error=0, FSM=IDLE. Stack contents are don't-care.
- FSM states:
  - IDLE: on IN_VALID=1, process the token and go to ACCUM.
  - ACCUM: on IN_VALID=1, process the token. On IN_VALID=0, go to IDLE and emit.
- Emit (registered at the first edge with IN_VALID=0 after a high run):
  - OUT_VALID=1 for exactly one cycle.
  - OUT = stack[0] if the sticky error is clear and depth==1, else 0.
  - OUT_ERR = sticky error code, or 4 if no prior error and depth!=1.
  - Pointer and sticky error are cleared in the same edge.
- OUT_VALID is 0 in every cycle not emitting. OUT/OUT_ERR hold their last values between emits.
- Back-to-back expressions require at least one IN_VALID=0 cycle. A single idle cycle is sufficient; the next token may arrive in the cycle right after the emit edge.
- Operand push: stack[sp] <= zero-extended IN; sp <= sp+1. If sp==DEPTH: no write, error 2.
- Opcodes (OP_MODE=1):
  - 4'b0001 ADD: b+a
  - 4'b0010 SUB: b-a
  - 4'b0100 MUL: low DATA_W bits of b*a
  - 4'b1000 NEG: unary, top <= 0-top
  - a = top entry, b = entry below it. Binary ops write stack[sp-2] and sp <= sp-1. NEG leaves sp unchanged.
  - Any other opcode: error 3, no state change.
- Underflow: binary op with sp<2, or NEG with sp==0 -> error 1, no stack change.
- All arithmetic is modulo 2^DATA_W; no saturation.
- Errors are sticky, first error wins. Once set, subsequent tokens of that expression are ignored (no pushes, no pointer moves).
- One token per cycle; no backpressure; all writes are registered.
- Empty expression is impossible: an IN_VALID high run always contains at least one token.
- Reset asserted mid-expression aborts it with no OUT_VALID. The first expression after reset release evaluates normally.

Decomposition:
- Package postfix_pkg holds:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_NEG
  - error codes ERR_NONE, ERR_UNDER, ERR_OVER, ERR_OPC, ERR_DEPTH
  - FSM state enum IDLE/ACCUM
- One sub-module, postfix_alu: combinational, parametrised by DATA_W. Inputs a, b, opcode; outputs result and illegal flag.
- Stack storage, pointer, FSM and error logic live in postfix_eval_p.

Test Plan:
- Tokens 3, 4, +, 2, * (OP_MODE 0,0,1,0,1), then IN_VALID=0 -> one-cycle OUT_VALID, OUT=14, OUT_ERR=0.
- Tokens 3, 5, - -> OUT=16'hFFFE (wrap); then 7, NEG -> OUT=16'hFFF9, OUT_ERR=0, with one idle cycle between the two expressions.
- Tokens 15, 15, *, 15, *, 15, *, 15, * -> OUT=16'h964F (mul wrap, 15^5 mod 2^16).
- Error cases:
  - Tokens 3, + -> OUT_ERR=1, OUT=0.
  - 9 pushes with DEPTH=8 -> OUT_ERR=2.
  - Opcode 4'b0011 -> OUT_ERR=3.
  - Tokens 1, 2 (no operator) -> OUT_ERR=4.
  - After each error expression, 2, 3, + -> OUT=5 (error cleared).
- RESET pulsed low after tokens 6, 7 -> outputs zero immediately, no OUT_VALID. Then 1, 1, + -> OUT=2.
- Parameter variant DATA_W=8, DEPTH=4: tokens 15, 15, * -> OUT=8'hE1; 5 pushes -> OUT_ERR=2.
